// File: rtl/rv32e_pkg.sv
// Shared definitions for the RV32E program-memory block: state encodings,
// the NOP instruction returned on blocked fetches, and the RV32E register count.
package rv32e_pkg;

    // RV32E has 16 integer registers (x0..x15).
    localparam int RV32E_NUM_REGS = 16;

    // addi x0, x0, 0
    localparam logic [31:0] RV32E_NOP_WORD = 32'h0000_0013;

    // One-hot state encoding, matching the CPU FSM style.
    typedef enum logic [3:0] {
        ST_HOLD = 4'b0001,
        ST_RUN  = 4'b0010,
        ST_LOAD = 4'b0100,
        ST_DONE = 4'b1000
    } pm_state_e;

endpackage

// File: rtl/rv32e_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words. A word is emitted
// combinationally with the fourth byte, or early with a byte flagged last;
// lanes not yet filled read as zero because the buffer is cleared after
// every emitted word.
module rv32e_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_accept,
    input  logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  lane;
    logic [31:0] shift_buf;
    logic [31:0] merged;

    // Merge the incoming byte into its lane and decide whether a word is complete.
    always_comb begin
        merged = shift_buf;
        merged[{lane, 3'b000} +: 8] = byte_in;
        word_valid = byte_accept && ((lane == 2'd3) || byte_last);
        word_data  = merged;
    end

    // Lane counter and shift buffer; cleared on reset, on load start and after each word.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            lane      <= 2'd0;
            shift_buf <= 32'd0;
        end else if (byte_accept) begin
            if (word_valid) begin
                lane      <= 2'd0;
                shift_buf <= 32'd0;
            end else begin
                lane      <= lane + 2'd1;
                shift_buf <= merged;
            end
        end
    end

endmodule

// File: rtl/rv32e_program_mem.sv
// Program memory on the far side of the CPU instruction-fetch bus, with a
// byte-stream boot loader. The CPU is held in reset while a program loads and
// released afterwards so it fetches from word 0.
//
// Loader handshake: a byte transfers on a rising edge where load_byte_valid
// and load_byte_ready are both high. load_byte_ready is registered and is
// high only in LOAD; valid may drop at any time, stalling the load without a
// timeout. load_last qualifies the byte it accompanies.
module rv32e_program_mem
    import rv32e_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] NOP_WORD    = RV32E_NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_program_addr_bus,
    output logic [31:0]       mem_program_data_bus,
    output logic              cpu_reset_n,
    input  logic              load_start,
    input  logic [7:0]        load_byte,
    input  logic              load_byte_valid,
    output logic              load_byte_ready,
    input  logic              load_last,
    output logic              load_busy,
    output logic              load_error,
    output logic [ADDR_W:0]   load_words,
    output logic [3:0]        dbg_state
);

    localparam logic [ADDR_W:0] DEPTH_CNT   = (ADDR_W + 1)'(DEPTH_WORDS);
    localparam logic [31:0]     ADDR_LIMIT  = 32'(DEPTH_WORDS);

    pm_state_e        state;
    pm_state_e        state_next;
    logic [ADDR_W:0]  ptr;
    logic [ADDR_W:0]  ptr_after;
    logic             ptr_full;
    logic             byte_accept;
    logic             load_begin;
    logic             word_valid;
    logic [31:0]      word_data;
    logic [31:0]      mem [DEPTH_WORDS];

    assign byte_accept = load_byte_valid && load_byte_ready;
    assign load_begin  = (state == ST_RUN) && load_start;
    assign ptr_full    = (ptr == DEPTH_CNT);
    assign ptr_after   = ptr_full ? ptr : ptr + 1'b1;
    assign dbg_state   = state;

    rv32e_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (load_begin),
        .byte_in     (load_byte),
        .byte_accept (byte_accept),
        .byte_last   (load_last),
        .word_valid  (word_valid),
        .word_data   (word_data)
    );

    // Next-state logic: HOLD lasts one cycle, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_HOLD: state_next = ST_RUN;
            ST_RUN:  if (load_start) state_next = ST_LOAD;
            ST_LOAD: if (byte_accept && load_last) state_next = ST_DONE;
            ST_DONE: state_next = ST_RUN;
            default: state_next = ST_HOLD;
        endcase
    end

    // State register, registered status outputs and the write pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ST_HOLD;
            cpu_reset_n     <= 1'b0;
            load_byte_ready <= 1'b0;
            load_busy       <= 1'b0;
            load_error      <= 1'b0;
            load_words      <= '0;
            ptr             <= '0;
        end else begin
            state           <= state_next;
            cpu_reset_n     <= (state_next == ST_RUN);
            load_byte_ready <= (state_next == ST_LOAD);
            load_busy       <= (state_next == ST_LOAD) || (state_next == ST_DONE);
            if (load_begin) begin
                ptr        <= '0;
                load_error <= 1'b0;
            end else if (word_valid) begin
                if (ptr_full) begin
                    load_error <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
                if (load_last) begin
                    load_words <= ptr_after;
                end
            end
        end
    end

    // Word commit into the array; contents survive reset, overflow writes are dropped.
    always_ff @(posedge clk) begin
        if (reset && word_valid && !ptr_full) begin
            mem[ptr[ADDR_W-1:0]] <= word_data;
        end
    end

    // Combinational fetch: only in RUN and only for in-range word indices.
    always_comb begin
        mem_program_data_bus = NOP_WORD;
        if ((state == ST_RUN) && (mem_program_addr_bus < ADDR_LIMIT)) begin
            mem_program_data_bus = mem[mem_program_addr_bus[ADDR_W-1:0]];
        end
    end

endmodule

// File: doc/rv32e_program_mem.md
Name: rv32e_program_mem

Overview:
- Program-memory responder on the far end of the CPU's instruction-fetch bus.
- Drives mem_program_data_bus from mem_program_addr_bus. The address is a word index, because the CPU advances pc by 1 per instruction.
- Includes a byte-stream boot loader that fills the memory with little-endian 32-bit words.
- Holds the CPU in reset through cpu_reset_n while loading, then releases it so execution starts at pc=0.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words stored.
- ADDR_W, 8, index width; must equal clog2(DEPTH_WORDS).
- NOP_WORD, 32'h0000_0013, word returned for out-of-range or blocked fetches (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low.
- mem_program_addr_bus  in  32  word index from the CPU pc.
- mem_program_data_bus  out  32  instruction word; combinational read.
- cpu_reset_n  out  1  synchronous active-low reset for the CPU, registered.
- load_start  in  1  single-cycle request to begin a program load.
- load_byte  in  8  loader data byte.
- load_byte_valid  in  1  byte present.
- load_byte_ready  out  1  block accepts a byte this cycle.
- load_last  in  1  qualifies the final byte of the image.
- load_busy  out  1  high in LOAD and DONE.
- load_error  out  1  sticky overflow flag.
- load_words  out  ADDR_W+1  number of words committed by the last load.

Behaviour:
- Read path, combinational:
  - data = mem[addr[ADDR_W-1:0]] when addr < DEPTH_WORDS and state==RUN.
  - Otherwise data = NOP_WORD.
  - Combinational is mandatory: the CPU changes pc on one edge and samples the data on the next.
- States: HOLD, RUN, LOAD, DONE.
- reset==0 at a clock edge:
  - state=HOLD, cpu_reset_n=0, load_busy=0, load_byte_ready=0, load_error=0, load_words=0, ptr=0, lane=0.
  - Memory contents are not cleared.
- HOLD -> RUN unconditionally after one cycle; cpu_reset_n becomes 1 on entry to RUN.
- RUN, load_start=1 -> LOAD:
  - Registered on entry: cpu_reset_n=0, load_busy=1, ptr=0, lane=0, shift buffer=0, load_error=0.
- LOAD:
  - load_byte_ready=1. A byte is accepted when valid&&ready.
  - Accepted byte goes to buffer bits [8*lane+7:8*lane]; lane increments mod 4.
  - Word commit happens when lane==3 or load_last is high with the byte.
    - The word is written to mem[ptr]; lanes not yet filled read as 0.
    - ptr increments and lane resets to 0.
  - Commit with ptr==DEPTH_WORDS: the write is discarded, load_error=1, ptr saturates.
  - Byte with load_last accepted -> DONE; load_words=ptr after that commit (saturated).
  - load_start ignored while in LOAD or DONE.
  - load_byte_valid=0 cycles stall the loader with no timeout; the CPU remains held.
- DONE:
  - One cycle; load_byte_ready=0, cpu_reset_n stays 0.
  - -> RUN, where cpu_reset_n=1 and load_busy=0. The CPU resets pc to 0 while held, so it fetches mem[0] first.
- load_byte_ready and cpu_reset_n are registered outputs with no combinational path from inputs.
- Simultaneous load_start and reset==0: reset wins.
- Reset mid-LOAD: the load is aborted. Words already committed remain; the flow returns through HOLD to RUN with the partial image.
- load_last on the first byte of a load: one word is committed (byte in lane 0, rest zero) and load_words=1.

Decomposition:
- Shared package rv32e_pkg holds:
  - the state encodings, one-hot 4-bit as used by the CPU FSM style;
  - the NOP_WORD constant;
  - the RV32E register count.
- Sub-module rv32e_byte_packer is natural. It owns the lane counter, shift buffer, and word_valid/word_data output, and gives 4-byte to 1-word packing with a last-flush. The memory array and FSM stay in the top.

Test Plan:
- Reset then idle, addr=0..3 -> data=NOP_WORD during HOLD; cpu_reset_n rises exactly 1 cycle after reset deasserts.
- load_start, then bytes 13 05 10 00 93 05 15 00 with last on the final byte:
  - mem[0]=32'h00100513 and mem[1]=32'h00150593;
  - load_words=2;
  - cpu_reset_n=0 throughout and returns to 1 exactly 2 cycles after the last byte is accepted;
  - data at addr=1 is 32'h00150593.
- Partial word: bytes AA BB CC with last -> mem[0]=32'h00CCBBAA, load_words=1.
- Overflow with DEPTH_WORDS=4: 20 bytes, last on byte 20 -> load_error=1, load_words=4, mem[0..3] hold the first 16 bytes; addr=4 returns NOP_WORD.
- Valid gaps and a load_start pulse mid-load -> identical memory image to the gap-free run; the mid-load load_start is ignored.
- reset asserted after 6 bytes -> mem[0] updated and mem[1] unchanged; state HOLD then RUN; load_busy=0, load_error=0.
